// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline: NOP encoding and
// the pipe-stage occupancy encoding, which doubles as the entry count.
package riscv_pkg;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } ps_state_e;

endpackage

// File: rtl/riscv_dff_en_clr.sv
// Enabled payload register with asynchronous reset and synchronous clear,
// both returning to the programmable bubble value.
module riscv_dff_en_clr #(
  parameter int                 BW_DATA = 32,
  parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [BW_DATA-1:0] i_d,
  output logic [BW_DATA-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)     o_q <= RST_VAL;
    else if (i_clr)  o_q <= RST_VAL;
    else if (i_en)   o_q <= i_d;
  end

endmodule

// File: rtl/riscv_pipe_stage.sv
// Elastic valid/ready pipeline register with flush; SKID=1 adds a second
// entry so o_ready comes straight from the state register.
module riscv_pipe_stage
  import riscv_pkg::*;
#(
  parameter int                 BW_DATA = 32,
  parameter int                 SKID    = 1,
  parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  input  logic [BW_DATA-1:0] i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic [BW_DATA-1:0] o_data,
  input  logic               i_ready,
  input  logic               i_flush,
  output logic [1:0]         o_cnt
);

  ps_state_e          state_q, state_d;
  logic               in_fire, out_fire;
  logic               main_en, skid_en;
  logic [BW_DATA-1:0] main_d, skid_q;

  assign o_valid  = (state_q != PS_EMPTY);
  assign o_ready  = (SKID != 0) ? (state_q != PS_SKID) : (!o_valid || i_ready);
  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;
  assign o_cnt    = state_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= PS_EMPTY;
    else         state_q <= state_d;
  end

  // With SKID=0 the FULL state only accepts while draining, so the
  // spill into PS_SKID is unreachable there.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = i_data;
    skid_en = 1'b0;
    if (i_flush) begin
      state_d = PS_EMPTY;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_FULL;
            main_en = 1'b1;
          end
        end
        PS_FULL: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = PS_SKID;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_SKID: begin
          if (out_fire) begin
            state_d = PS_FULL;
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  riscv_dff_en_clr #(.BW_DATA(BW_DATA), .RST_VAL(RST_VAL)) u_main (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (i_flush),
    .i_en   (main_en),
    .i_d    (main_d),
    .o_q    (o_data)
  );

  riscv_dff_en_clr #(.BW_DATA(BW_DATA), .RST_VAL(RST_VAL)) u_skid (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (i_flush),
    .i_en   (skid_en),
    .i_d    (i_data),
    .o_q    (skid_q)
  );

  a_cnt_legal: assert property (@(posedge i_clk) disable iff (!i_rstn) o_cnt != 2'd3);

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Scoreboard bench: directed SKID=1 scenarios plus a random SKID=0 run.
module tb_riscv_pipe_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        v1 = 1'b0, r1 = 1'b0, fl1 = 1'b0;
  logic [31:0] d1 = '0;
  logic        ordy1, oval1;
  logic [31:0] od1;
  logic [1:0]  cnt1;
  logic        v0 = 1'b0, r0 = 1'b0, fl0 = 1'b0;
  logic [31:0] d0 = '0;
  logic        ordy0, oval0;
  logic [31:0] od0;
  logic [1:0]  cnt0;

  int total = 0;
  int bad   = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  always #5 clk = ~clk;

  riscv_pipe_stage #(.BW_DATA(32), .SKID(1), .RST_VAL(32'h13)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v1), .i_data(d1), .o_ready(ordy1),
    .o_valid(oval1), .o_data(od1), .i_ready(r1), .i_flush(fl1), .o_cnt(cnt1)
  );

  riscv_pipe_stage #(.BW_DATA(32), .SKID(0), .RST_VAL(32'h0)) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v0), .i_data(d0), .o_ready(ordy0),
    .o_valid(oval0), .o_data(od0), .i_ready(r0), .i_flush(fl0), .o_cnt(cnt0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic v, input logic [31:0] d,
                               input logic r, input logic fl);
    @(posedge clk);
    #1;
    if (sel) begin v1 = v; d1 = d; r1 = r; fl1 = fl; end
    else     begin v0 = v; d0 = d; r0 = r; fl0 = fl; end
  endtask

  // Reference model: queue length is the occupancy, queue head is the next output.
  always @(negedge clk) begin
    if (!rstn) begin
      q1.delete();
      q0.delete();
    end else begin
      checkOutput("cnt1", {30'd0, cnt1}, q1.size());
      checkOutput("valid1", {31'd0, oval1}, {31'd0, q1.size() != 0});
      checkOutput("ready1", {31'd0, ordy1}, {31'd0, q1.size() != 2});
      if (fl1) q1.delete();
      else begin
        if (oval1 && r1) begin
          if (q1.size() == 0) checkOutput("sb1_spurious", {31'd0, oval1}, 32'd0);
          else checkOutput("sb1_data", od1, q1.pop_front());
        end
        if (v1 && ordy1) q1.push_back(d1);
      end

      checkOutput("cnt0", {30'd0, cnt0}, q0.size());
      checkOutput("cnt0_max", {31'd0, cnt0 <= 2'd1}, 32'd1);
      checkOutput("ready0", {31'd0, ordy0}, {31'd0, (q0.size() == 0) || r0});
      if (fl0) q0.delete();
      else begin
        if (oval0 && r0) begin
          if (q0.size() == 0) checkOutput("sb0_spurious", {31'd0, oval0}, 32'd0);
          else checkOutput("sb0_data", od0, q0.pop_front());
        end
        if (v0 && ordy0) q0.push_back(d0);
      end
    end
  end

  initial begin
    // reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, oval1}, 32'd0);
    checkOutput("rst_data", od1, 32'h13);
    checkOutput("rst_cnt", {30'd0, cnt1}, 32'd0);
    rstn = 1'b1;
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("idle_ready", {31'd0, ordy1}, 32'd1);
    checkOutput("idle_valid", {31'd0, oval1}, 32'd0);
    checkOutput("idle_data", od1, 32'h13);

    // streaming 1..8 without bubbles
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 1, i, 1, 0);
      if (i > 1) begin
        checkOutput("stream_data", od1, i - 1);
        checkOutput("stream_cnt", {30'd0, cnt1}, 32'd1);
      end
    end
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("stream_last", od1, 32'd8);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("stream_empty", {31'd0, oval1}, 32'd0);

    // backpressure A,B,C
    applyStimulus(1, 1, 32'hA, 1, 0);
    applyStimulus(1, 1, 32'hB, 0, 0);
    checkOutput("bp_a", od1, 32'hA);
    applyStimulus(1, 1, 32'hC, 0, 0);
    checkOutput("bp_cnt2", {30'd0, cnt1}, 32'd2);
    checkOutput("bp_ready0", {31'd0, ordy1}, 32'd0);
    checkOutput("bp_hold_a", od1, 32'hA);
    applyStimulus(1, 1, 32'hC, 1, 0);
    checkOutput("bp_stall_data", od1, 32'hA);
    checkOutput("bp_stall_cnt", {30'd0, cnt1}, 32'd2);
    applyStimulus(1, 1, 32'hC, 1, 0);
    checkOutput("bp_b", od1, 32'hB);
    checkOutput("bp_b_cnt", {30'd0, cnt1}, 32'd1);
    checkOutput("bp_b_ready", {31'd0, ordy1}, 32'd1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("bp_c", od1, 32'hC);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("bp_done", {31'd0, oval1}, 32'd0);

    // flush in SKID_FULL with both handshakes active
    applyStimulus(1, 1, 32'h55, 0, 0);
    applyStimulus(1, 1, 32'h66, 0, 0);
    applyStimulus(1, 1, 32'h77, 1, 1);
    checkOutput("fl_pre_cnt", {30'd0, cnt1}, 32'd2);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("fl_valid", {31'd0, oval1}, 32'd0);
    checkOutput("fl_cnt", {30'd0, cnt1}, 32'd0);
    checkOutput("fl_data", od1, 32'h13);
    checkOutput("fl_ready", {31'd0, ordy1}, 32'd1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("fl_dropped", {31'd0, oval1}, 32'd0);

    // asynchronous reset while two entries are held
    applyStimulus(1, 1, 32'h88, 0, 0);
    applyStimulus(1, 1, 32'h99, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ar_pre_cnt", {30'd0, cnt1}, 32'd2);
    #1 rstn = 1'b0;
    #1;
    checkOutput("ar_valid", {31'd0, oval1}, 32'd0);
    checkOutput("ar_data", od1, 32'h13);
    checkOutput("ar_cnt", {30'd0, cnt1}, 32'd0);
    applyStimulus(1, 0, 0, 1, 0);
    rstn = 1'b1;
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("ar_after", {31'd0, oval1}, 32'd0);

    // SKID=0 random traffic with occasional flush
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    checkOutput("drain0", q0.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_pipe_stage.md
Name: riscv_pipe_stage

Overview:
Parametrised elastic pipeline register for the RISC-V core: the next generation of the plain enabled D flip-flop. It adds a valid/ready handshake, synchronous flush to a programmable bubble value, and an optional 2-entry skid buffer, which gives full throughput with registered upstream ready. It sits between core stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces hand-wired enable/stall logic.

Parameters:
BW_DATA, 32, payload width in bits (>=1)
SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single register with combinational o_ready
RST_VAL, 0, payload value on reset and flush (e.g. 32'h00000013 NOP for instruction stages), width BW_DATA

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_valid  input  1  upstream payload valid
i_data  input  BW_DATA  upstream payload
o_ready  output  1  stage can accept (upstream handshake)
o_valid  output  1  downstream payload valid
o_data  output  BW_DATA  downstream payload
i_ready  input  1  downstream can accept
i_flush  input  1  synchronous kill of all held entries
o_cnt  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- Reset: i_rstn asynchronous, active-low; clock i_clk. While reset is asserted: o_valid=0, o_data=RST_VAL, skid register=RST_VAL, o_cnt=0, state=EMPTY. o_ready=1 after reset (both modes).
- Handshake: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready. A payload transfers only on a fire. o_valid/o_data must not change while o_valid=1 and i_ready=0, except on flush.
- Latency: 1 cycle from in_fire to o_valid when the stage is empty.
- SKID=1, states: EMPTY (cnt 0), FULL (cnt 1, main valid), SKID_FULL (cnt 2, main and skid valid).
  - o_ready = (state != SKID_FULL), decoded from the state register only. It has no combinational path from i_ready.
  - o_valid = (state != EMPTY).
  - EMPTY: in_fire -> FULL, main<=i_data.
  - FULL: in_fire & out_fire -> FULL, main<=i_data. in_fire & !out_fire -> SKID_FULL, skid<=i_data. !in_fire & out_fire -> EMPTY, main holds its value. Neither fires -> hold.
  - SKID_FULL: out_fire -> FULL, main<=skid. Otherwise hold. No in_fire is possible.
  - Ordering is strict FIFO: the skid entry is never presented before main.
- SKID=0: single register.
  - o_ready = !o_valid | i_ready (combinational).
  - in_fire loads the register and sets o_valid.
  - out_fire without in_fire clears o_valid; o_data holds.
- Flush: i_flush=1 at a rising edge forces state=EMPTY, o_valid=0, o_cnt=0, main<=RST_VAL, skid<=RST_VAL. Flush has priority over a simultaneous in_fire and out_fire. A payload presented in the flush cycle is dropped; upstream must treat it as consumed only if o_ready was 1. o_ready is 1 on the cycle after a flush.
- o_cnt equals the state encoding: EMPTY=0, FULL=1, SKID_FULL=2. The value 3 is illegal; an assertion must fire if it occurs.
- Reset asserted mid-transfer discards all entries immediately (asynchronous). No partial state may survive.
- Throughput: with i_valid=i_ready=1 continuously, one transfer per cycle in both modes.
- No X propagation: o_data is always a defined register value.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP constant RV_NOP = 32'h00000013, used as RST_VAL for instruction stages.
  - State encoding constants PS_EMPTY=2'd0, PS_FULL=2'd1, PS_SKID=2'd2.
- Sub-module: riscv_dff_en_clr, a BW_DATA-wide register with i_en and synchronous clear to RST_VAL. It is instantiated for main and skid. Control FSM stays in riscv_pipe_stage.

Test Plan:
- Reset and idle (SKID=1, RST_VAL=32'h13): hold i_rstn=0 for 3 cycles, then release -> o_valid=0, o_data=32'h13, o_cnt=0, o_ready=1.
- Streaming: drive i_valid=1, i_ready=1 with data 1,2,3,...,8 on consecutive cycles -> o_data shows 1..8 on consecutive cycles starting 1 cycle later, o_cnt=1 throughout, no bubbles.
- Backpressure: stream A,B,C; drop i_ready to 0 after A is presented.
  - Expected: B goes to skid, o_cnt=2, o_ready=0 next cycle; C is held upstream.
  - Raise i_ready -> output order is A,B,C with no loss or duplication.
- Flush priority: in SKID_FULL with i_valid=1 and i_ready=1, pulse i_flush -> next cycle o_valid=0, o_cnt=0, o_data=32'h13, o_ready=1; the incoming payload is absent from the output.
- Async reset mid-operation: assert i_rstn=0 between clock edges while o_cnt=2 -> o_valid=0 and o_data=RST_VAL immediately, without waiting for a clock edge.
- SKID=0 random: random i_valid/i_ready for 10k cycles, scoreboard against a reference queue.
  - o_ready must equal !o_valid | i_ready every cycle.
  - o_cnt must never exceed 1.
  - Output sequence must match the input sequence exactly.
